lbp_scan_ctrl: RTL



---
 rtl/lbp_scan_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lbp_scan_ctrl.sv
// Snake-order scan sequencer for the LBP engine: walks the 3x3 window centre over a
// 128x128 image and drives the phase strobes and cycle counter consumed by gray_addr_ctrl.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for gray_ready
// INIT   | initial 3x3 fill, cycle 0..INIT_LAST
// OUT    | result for lbp_addr valid, held until lbp_ready
// MV_R   | shift window one column right, cycle 0..MOVE_LAST
// MV_D   | shift window one row down, cycle 0..MOVE_LAST
// MV_L   | shift window one column left, cycle 0..MOVE_LAST
// DONE   | whole image processed, exited only by reset
module lbp_scan_ctrl #(
    parameter logic [6:0] ROW_FIRST = 7'd1,
    parameter logic [6:0] ROW_LAST  = 7'd126,
    parameter logic [6:0] COL_LAST  = 7'd126,
    parameter logic [3:0] INIT_LAST = 4'd10,
    parameter logic [3:0] MOVE_LAST = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gray_ready,
    input  logic        lbp_ready,
    output logic        initialize,
    output logic        right,
    output logic        down,
    output logic        left,
    output logic [3:0]  cycle,
    output logic [13:0] lbp_addr,
    output logic        lbp_valid,
    output logic        finish
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_OUT, S_MV_R, S_MV_D, S_MV_L, S_DONE
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    state_t     state, state_nxt;
    logic [3:0] cycle_q, cycle_nxt;
    logic [6:0] row, row_nxt;
    logic [6:0] col, col_nxt;
    logic       dir, dir_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cycle_q <= 4'd0;
            row     <= ROW_FIRST;
            col     <= ROW_FIRST;
            dir     <= DIR_RIGHT;
        end else begin
            state   <= state_nxt;
            cycle_q <= cycle_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            dir     <= dir_nxt;
        end
    end

    // The centre only moves on the last cycle of a move; gray_addr_ctrl reads the old centre until then.
    always_comb begin
        state_nxt = state;
        cycle_nxt = cycle_q;
        row_nxt   = row;
        col_nxt   = col;
        dir_nxt   = dir;
        case (state)
            S_IDLE: begin
                if (gray_ready) begin
                    state_nxt = S_INIT;
                    cycle_nxt = 4'd0;
                end
            end
            S_INIT: begin
                if (cycle_q == INIT_LAST) begin
                    state_nxt = S_OUT;
                    cycle_nxt = 4'd0;
                end else begin
                    cycle_nxt = cycle_q + 4'd1;
                end
            end
            S_OUT: begin
                if (lbp_ready) begin
                    if (dir == DIR_RIGHT && col < COL_LAST) begin
                        state_nxt = S_MV_R;
                    end else if (dir == DIR_LEFT && col > ROW_FIRST) begin
                        state_nxt = S_MV_L;
                    end else if (row < ROW_LAST) begin
                        state_nxt = S_MV_D;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_MV_R, S_MV_D, S_MV_L: begin
                if (cycle_q == MOVE_LAST) begin
                    state_nxt = S_OUT;
                    cycle_nxt = 4'd0;
                    case (state)
                        S_MV_R:  col_nxt = col + 7'd1;
                        S_MV_L:  col_nxt = col - 7'd1;
                        default: begin
                            row_nxt = row + 7'd1;
                            dir_nxt = ~dir;
                        end
                    endcase
                end else begin
                    cycle_nxt = cycle_q + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
                cycle_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        initialize = 1'b0;
        right      = 1'b0;
        down       = 1'b0;
        left       = 1'b0;
        lbp_valid  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_INIT:  initialize = 1'b1;
            S_MV_R:  right      = 1'b1;
            S_MV_D:  down       = 1'b1;
            S_MV_L:  left       = 1'b1;
            S_OUT:   lbp_valid  = 1'b1;
            S_DONE:  finish     = 1'b1;
            default: ;
        endcase
    end

    assign cycle    = cycle_q;
    assign lbp_addr = {row, col};

endmodule
